fft_stage_addr_seq: RTL
=======================

FFT_STAGE_ADDR_SEQ -- requirements
Module: fft_stage_addr_seq

Interface
REQ-001 SHALL have parameter AWL, default 5, meaning max log2(N) and the address width of A_ADDR/B_ADDR.
REQ-002 SHALL have derived localparam LNW = $clog2(AWL+1), meaning the width of LOG_N and STAGE.
REQ-003 SHALL have port CLK  in  1  clock, all state on rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port START  in  1  request one full transform sequence.
REQ-006 SHALL have port LOG_N  in  LNW  log2 of transform size, sampled on an accepted START.
REQ-007 SHALL have port READY  in  1  consumer accepts the current address pair.
REQ-008 SHALL have port VALID  out  1  A_ADDR/B_ADDR/TW_ADDR/STAGE/STAGE_LAST are valid.
REQ-009 SHALL have port A_ADDR  out  AWL  butterfly upper-leg address.
REQ-010 SHALL have port B_ADDR  out  AWL  butterfly lower-leg address.
REQ-011 SHALL have port TW_ADDR  out  AWL-1  twiddle ROM index (present only under BAG_TWIDDLE_EN).
REQ-012 SHALL have port STAGE  out  LNW  current stage index s.
REQ-013 SHALL have port STAGE_LAST  out  1  current pair is the last pair of stage s.
REQ-014 SHALL have port BUSY  out  1  high when not in IDLE.
REQ-015 SHALL have port DONE  out  1  one-cycle pulse after the final pair is accepted.

Function
REQ-016 SHALL implement FSM IDLE->RUN on START; RUN->DONE on the handshake of the last pair of the last stage; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL ignore START while BUSY, in RUN or in DONE.
REQ-018 SHALL, on START in IDLE, latch L = min(LOG_N, AWL); if L==0, SHALL go IDLE->DONE with no VALID.
REQ-019 SHALL assert VALID during RUN only, with the first pair registered and VALID high in the cycle after START.
REQ-020 SHALL advance only on VALID&&READY; with READY low, all outputs hold stable.
REQ-021 SHALL step pair index p = 0..2^(L-1)-1 per stage, for stages s = 0..L-1; lay = 1<<s.
REQ-022 SHALL compute A = ((p>>s)<<(s+1)) | (p & (lay-1)), i.e. a zero inserted at bit s, and B = A | lay.
REQ-023 SHALL keep A/B bits at positions >= L at zero.
REQ-024 SHALL set STAGE_LAST = (p == 2^(L-1)-1); the handshake of that pair resets p to 0 and increments s.
REQ-025 SHALL compute TW_ADDR = (p & (lay-1)) << (AWL-1-s), indexing a 2^(AWL-1)-entry W_(2^AWL) table independent of L.
REQ-026 SHALL raise DONE only in the DONE state, and SHALL hold BUSY high in RUN and DONE.
REQ-027 SHALL register all outputs, with no combinational path from READY or START to any output.

Reset
REQ-028 SHALL, on RST, force IDLE with p=0, s=0, L=AWL, and VALID, DONE, BUSY, STAGE_LAST, STAGE, A_ADDR, B_ADDR and TW_ADDR all 0.
REQ-029 SHALL, on RST mid-RUN, abandon the sequence with no DONE, and require a new START to restart from stage 0.
REQ-030 SHALL give RST priority over START and READY in the same cycle.

Configuration
REQ-031 SHALL provide macro BAG_TWIDDLE_EN: when defined, the TW_ADDR port and its logic exist; when undefined, the port and its logic are absent, with A/B/handshake behaviour unchanged.

Structure
REQ-032 SHALL place FSM state encoding (IDLE/RUN/DONE) and the LNW helper function in shared package fft_pkg.
REQ-033 SHALL have one natural sub-module, fft_bit_insert (combinational zero-insert at bit s), reusable by the bit-reverse unit.

Verification
REQ-034 SHALL verify, with AWL=5, LOG_N=3 and READY=1: s0 pairs (0,1)(2,3)(4,5)(6,7), s1 pairs (0,2)(1,3)(4,6)(5,7), s2 pairs (0,4)(1,5)(2,6)(3,7); 12 VALID cycles, STAGE_LAST on the 4th/8th/12th, DONE one cycle after the 12th.
REQ-035 SHALL verify, with BAG_TWIDDLE_EN, AWL=5 and LOG_N=3: TW_ADDR s0 = 0,0,0,0; s1 = 0,8,0,8; s2 = 0,4,8,12.
REQ-036 SHALL verify that READY held low for 3 cycles at pair (1,3) keeps outputs unchanged, and that the sequence resumes with (4,6).
REQ-037 SHALL verify that LOG_N=0 gives DONE with zero VALID cycles, and that LOG_N=7 with AWL=5 runs L=5 (80 pairs).
REQ-038 SHALL verify that RST asserted at s1 p2 gives all outputs 0 and no DONE, and that the next START restarts at (0,1).
REQ-039 SHALL verify that START pulsed during RUN changes neither the sequence nor L.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT address-generation blocks: FSM encoding and
// the LOG_N/STAGE width helper.
package fft_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } fsm_t;

   // Width needed to hold a log2 size in the range 0..awl.
   function automatic int lnw(input int awl);
      return $clog2(awl + 1);
   endfunction

endpackage

// File: rtl/fft_bit_insert.sv
// Combinational zero-insert at bit position POS: bits below POS pass through,
// bits at and above POS move up by one. Also usable by the bit-reverse unit.
module fft_bit_insert
   import fft_pkg::*;
#(
   parameter  int W  = 5,
   localparam int SW = lnw(W)
) (
   input  logic [W-2:0]  din,
   input  logic [SW-1:0] pos,
   output logic [W-1:0]  dout
);

   logic [W-1:0] ext;
   logic [W-1:0] mask;

   always_comb begin
      ext  = {1'b0, din};
      mask = (W'(1) << pos) - W'(1);
      dout = (ext & mask) | ((ext & ~mask) << 1);
   end

endmodule

// File: rtl/fft_stage_addr_seq.sv
// Radix-2 FFT butterfly address sequencer: walks every (A,B) pair of every
// stage under a valid/ready handshake. Define BAG_TWIDDLE_EN to add TW_ADDR.
module fft_stage_addr_seq
   import fft_pkg::*;
#(
   parameter  int AWL = 5,
   localparam int LNW = lnw(AWL)
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           START,
   input  logic [LNW-1:0] LOG_N,
   input  logic           READY,
   output logic           VALID,
   output logic [AWL-1:0] A_ADDR,
   output logic [AWL-1:0] B_ADDR,
`ifdef BAG_TWIDDLE_EN
   output logic [AWL-2:0] TW_ADDR,
`endif
   output logic [LNW-1:0] STAGE,
   output logic           STAGE_LAST,
   output logic           BUSY,
   output logic           DONE
);

   localparam int PW = AWL - 1;

   fsm_t           state, state_nx;
   logic [PW-1:0]  p, p_nx, p_last;
   logic [LNW-1:0] s, s_nx, l, l_nx;
   logic [AWL-1:0] span, a_nx, lay_nx;
   logic           run_nx;

   always_comb begin
      state_nx = state;
      p_nx     = p;
      s_nx     = s;
      l_nx     = l;
      if (state == S_IDLE && START)
         l_nx = (LOG_N > LNW'(AWL)) ? LNW'(AWL) : LOG_N;
      span   = AWL'(1) << (l_nx - LNW'(1));
      p_last = PW'(span - AWL'(1));
      case (state)
         S_IDLE: if (START) begin
            p_nx     = '0;
            s_nx     = '0;
            state_nx = (l_nx == '0) ? S_DONE : S_RUN;
         end
         // VALID is high for the whole of RUN, so READY alone is the handshake.
         S_RUN: if (READY) begin
            if (p == p_last) begin
               p_nx = '0;
               if (s == l - LNW'(1)) begin
                  s_nx     = '0;
                  state_nx = S_DONE;
               end else begin
                  s_nx = s + LNW'(1);
               end
            end else begin
               p_nx = p + PW'(1);
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   fft_bit_insert #(.W(AWL)) u_ins (
      .din  (p_nx),
      .pos  (s_nx),
      .dout (a_nx)
   );

   assign run_nx = (state_nx == S_RUN);
   assign lay_nx = AWL'(1) << s_nx;

`ifdef BAG_TWIDDLE_EN
   logic [PW-1:0] tw_mask, tw_nx;
   always_comb begin
      tw_mask = (PW'(1) << s_nx) - PW'(1);
      tw_nx   = (p_nx & tw_mask) << (LNW'(PW) - s_nx);
   end
`endif

   // Outputs are registered from next-state values so they line up with state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         p          <= '0;
         s          <= '0;
         l          <= LNW'(AWL);
         VALID      <= 1'b0;
         DONE       <= 1'b0;
         BUSY       <= 1'b0;
         STAGE_LAST <= 1'b0;
         STAGE      <= '0;
         A_ADDR     <= '0;
         B_ADDR     <= '0;
`ifdef BAG_TWIDDLE_EN
         TW_ADDR    <= '0;
`endif
      end else begin
         state      <= state_nx;
         p          <= p_nx;
         s          <= s_nx;
         l          <= l_nx;
         VALID      <= run_nx;
         DONE       <= (state_nx == S_DONE);
         BUSY       <= (state_nx != S_IDLE);
         STAGE_LAST <= run_nx && (p_nx == p_last);
         STAGE      <= run_nx ? s_nx : '0;
         A_ADDR     <= run_nx ? a_nx : '0;
         B_ADDR     <= run_nx ? (a_nx | lay_nx) : '0;
`ifdef BAG_TWIDDLE_EN
         TW_ADDR    <= run_nx ? tw_nx : '0;
`endif
      end
   end

endmodule
